ddr_fifo_burst_scheduler: RTL and testbench

Sequences the DDR-backed FIFO by deciding, one burst at a time, whether the AXI master moves data from the input staging FIFO into DDR (write burst) or from DDR into the output staging FIFO (read burst). It owns the DDR ring-buffer write and read pointers, the burst-occupancy count and the full/empty status. It sits between the staging-FIFO level logic and the AXI write/read channel blocks, and replaces their free-running address counters with scheduled start addresses.

---
 rtl/ddr_fifo_pkg.sv | 24 ++
 rtl/ddr_fifo_watchdog.sv | 45 ++++
 rtl/ddr_fifo_burst_scheduler.sv | 155 +++++++++++++++
 tb/tb_ddr_fifo_burst_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ddr_fifo_pkg.sv
// Shared types and helpers for the DDR ring-buffer burst scheduler.
// PTR_WIDTH/LEVEL_WIDTH describe the default 1024-burst ring.
package ddr_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_BUSY = 2'd1,
        ST_RD_BUSY = 2'd2
    } sched_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    localparam int DEF_REGION_BURSTS = 1024;
    localparam int PTR_WIDTH         = clog2(DEF_REGION_BURSTS);
    localparam int LEVEL_WIDTH       = PTR_WIDTH + 1;

endpackage

// File: rtl/ddr_fifo_watchdog.sv
// Burst watchdog: counts cycles spent waiting for a done pulse and raises a sticky error.
// Present only when DDR_FIFO_WATCHDOG_EN is defined.
`ifdef DDR_FIFO_WATCHDOG_EN
module ddr_fifo_watchdog
    import ddr_fifo_pkg::*;
#(
    parameter int WDOG_CYCLES = 4096
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic busy_i,
    input  logic done_i,
    output logic timeout_o,
    output logic wdog_err_o
);

    localparam int            CW   = clog2(WDOG_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(WDOG_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q;

    assign timeout_o  = busy_i && !done_i && (cnt_q == LAST);
    assign wdog_err_o = err_q;

    // The scheduler always passes through IDLE between bursts, so leaving busy clears the count.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!busy_i || done_i || timeout_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_q | timeout_o;
        end
    end

endmodule
`endif

// File: rtl/ddr_fifo_burst_scheduler.sv
// Schedules one write or read burst at a time over a DDR ring buffer and tracks its fill level.
// Optional burst watchdog enabled by DDR_FIFO_WATCHDOG_EN.
module ddr_fifo_burst_scheduler
    import ddr_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH    = 30,
    parameter int BASE_ADDR     = 0,
    parameter int BURST_BYTES   = 1024,
    parameter int BURST_LEN     = 16,
    parameter int REGION_BURSTS = DEF_REGION_BURSTS,
    parameter int LVL_WIDTH     = 10,
    parameter int WDOG_CYCLES   = 4096
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic [LVL_WIDTH-1:0]          in_fifo_words,
    input  logic [LVL_WIDTH-1:0]          out_fifo_space,
    input  logic                          wr_done,
    input  logic                          rd_done,
    output logic                          start_wr_burst,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic                          start_rd_burst,
    output logic [ADDR_WIDTH-1:0]         rd_addr,
    output logic [clog2(REGION_BURSTS):0] ddr_level,
    output logic                          ddr_full,
    output logic                          ddr_empty,
    output logic                          busy,
    output logic                          wdog_err
);

    localparam int                   PW          = clog2(REGION_BURSTS);
    localparam int                   LW          = PW + 1;
    localparam logic [LVL_WIDTH-1:0] BURST_WORDS = LVL_WIDTH'(BURST_LEN);
    localparam logic [LW-1:0]        FULL_LEVEL  = LW'(REGION_BURSTS);

    sched_state_e  state_q, state_d;
    logic          prio_q, prio_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          start_wr_q, start_wr_d;
    logic          start_rd_q, start_rd_d;
    logic          full_q, empty_q, busy_q;
    logic          wr_ok, rd_ok, timeout;

    function automatic logic [ADDR_WIDTH-1:0] burst_addr(input logic [PW-1:0] ptr);
        return ADDR_WIDTH'(BASE_ADDR) + (ADDR_WIDTH'(ptr) * ADDR_WIDTH'(BURST_BYTES));
    endfunction

    assign wr_ok = (in_fifo_words >= BURST_WORDS) && !full_q;
    assign rd_ok = (out_fifo_space >= BURST_WORDS) && !empty_q;

`ifdef DDR_FIFO_WATCHDOG_EN
    logic dir_done;

    assign dir_done = ((state_q == ST_WR_BUSY) && wr_done) ||
                      ((state_q == ST_RD_BUSY) && rd_done);

    ddr_fifo_watchdog #(
        .WDOG_CYCLES(WDOG_CYCLES)
    ) u_wdog (
        .clk_i      (M_AXI_ACLK),
        .rst_ni     (M_AXI_ARESETN),
        .busy_i     (state_q != ST_IDLE),
        .done_i     (dir_done),
        .timeout_o  (timeout),
        .wdog_err_o (wdog_err)
    );
`else
    logic wdog_cycles_unused;

    assign wdog_cycles_unused = (WDOG_CYCLES != 0);
    assign timeout            = 1'b0;
    assign wdog_err           = 1'b0;
`endif

    // prio is a round-robin bit: it only matters when both directions are eligible.
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        start_wr_d = 1'b0;
        start_rd_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_ok && (!rd_ok || !prio_q)) begin
                    state_d    = ST_WR_BUSY;
                    start_wr_d = 1'b1;
                    prio_d     = 1'b1;
                end else if (rd_ok) begin
                    state_d    = ST_RD_BUSY;
                    start_rd_d = 1'b1;
                    prio_d     = 1'b0;
                end
            end
            ST_WR_BUSY: begin
                if (wr_done) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    level_d  = level_q + 1'b1;
                    state_d  = ST_IDLE;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_BUSY: begin
                if (rd_done) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    level_d  = level_q - 1'b1;
                    state_d  = ST_IDLE;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q    <= ST_IDLE;
            prio_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            start_wr_q <= 1'b0;
            start_rd_q <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            start_wr_q <= start_wr_d;
            start_rd_q <= start_rd_d;
            full_q     <= (level_d == FULL_LEVEL);
            empty_q    <= (level_d == '0);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign start_wr_burst = start_wr_q;
    assign start_rd_burst = start_rd_q;
    assign wr_addr        = burst_addr(wr_ptr_q);
    assign rd_addr        = burst_addr(rd_ptr_q);
    assign ddr_level      = level_q;
    assign ddr_full       = full_q;
    assign ddr_empty      = empty_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_ddr_fifo_burst_scheduler.sv
// Randomized self-checking bench for ddr_fifo_burst_scheduler on a 4-burst ring.
// Models the watchdog too when DDR_FIFO_WATCHDOG_EN is defined.
module tb_ddr_fifo_burst_scheduler;

    localparam int ADDR_WIDTH    = 30;
    localparam int BASE_ADDR     = 0;
    localparam int BURST_BYTES   = 1024;
    localparam int BURST_LEN     = 16;
    localparam int REGION_BURSTS = 4;
    localparam int LVL_WIDTH     = 10;
    localparam int WDOG_CYCLES   = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [LVL_WIDTH-1:0]  inFifoWords = '0;
    logic [LVL_WIDTH-1:0]  outFifoSpace = '0;
    logic                  wrDone = 1'b0;
    logic                  rdDone = 1'b0;
    logic                  startWr, startRd, ddrFull, ddrEmpty, busyOut, wdogErr;
    logic [ADDR_WIDTH-1:0] wrAddr, rdAddr;
    logic [2:0]            ddrLevel;

    int testsRun = 0;
    int testsFailed = 0;

    // Reference model: burst counts and a direction-in-flight marker (0 none, 1 write, 2 read).
    int mMode = 0;
    int mLevel = 0;
    int mWrCount = 0;
    int mRdCount = 0;
    int mWaited = 0;
    bit mReadTurn = 0;
    bit mStartWr = 0;
    bit mStartRd = 0;
    bit mErr = 0;

    ddr_fifo_burst_scheduler #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .BASE_ADDR    (BASE_ADDR),
        .BURST_BYTES  (BURST_BYTES),
        .BURST_LEN    (BURST_LEN),
        .REGION_BURSTS(REGION_BURSTS),
        .LVL_WIDTH    (LVL_WIDTH),
        .WDOG_CYCLES  (WDOG_CYCLES)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .in_fifo_words (inFifoWords),
        .out_fifo_space(outFifoSpace),
        .wr_done       (wrDone),
        .rd_done       (rdDone),
        .start_wr_burst(startWr),
        .wr_addr       (wrAddr),
        .start_rd_burst(startRd),
        .rd_addr       (rdAddr),
        .ddr_level     (ddrLevel),
        .ddr_full      (ddrFull),
        .ddr_empty     (ddrEmpty),
        .busy          (busyOut),
        .wdog_err      (wdogErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    task automatic modelReset();
        mMode = 0; mLevel = 0; mWrCount = 0; mRdCount = 0; mWaited = 0;
        mReadTurn = 0; mStartWr = 0; mStartRd = 0; mErr = 0;
    endtask

    task automatic modelStep(input int inW, input int outS, input bit wrD, input bit rdD);
        bit wantW, wantR;
        mStartWr = 0;
        mStartRd = 0;
        if (mMode == 0) begin
            wantW = (inW >= BURST_LEN) && (mLevel < REGION_BURSTS);
            wantR = (outS >= BURST_LEN) && (mLevel > 0);
            if (wantW && wantR) begin
                if (mReadTurn) wantW = 0;
                else wantR = 0;
            end
            if (wantW) begin
                mMode = 1; mStartWr = 1; mReadTurn = 1; mWaited = 0;
            end else if (wantR) begin
                mMode = 2; mStartRd = 1; mReadTurn = 0; mWaited = 0;
            end
        end else if ((mMode == 1 && wrD) || (mMode == 2 && rdD)) begin
            if (mMode == 1) begin mWrCount++; mLevel++; end
            else begin mRdCount++; mLevel--; end
            mMode = 0;
        end else begin
            mWaited++;
`ifdef DDR_FIFO_WATCHDOG_EN
            if (mWaited == WDOG_CYCLES) begin
                mErr = 1;
                mMode = 0;
            end
`endif
        end
    endtask

    task automatic checkAll();
        checkOutput("start_wr_burst", 32'(startWr), 32'(mStartWr));
        checkOutput("start_rd_burst", 32'(startRd), 32'(mStartRd));
        checkOutput("wr_addr", 32'(wrAddr), 32'(BASE_ADDR + (mWrCount % REGION_BURSTS) * BURST_BYTES));
        checkOutput("rd_addr", 32'(rdAddr), 32'(BASE_ADDR + (mRdCount % REGION_BURSTS) * BURST_BYTES));
        checkOutput("ddr_level", 32'(ddrLevel), 32'(mLevel));
        checkOutput("ddr_full", 32'(ddrFull), 32'(mLevel == REGION_BURSTS));
        checkOutput("ddr_empty", 32'(ddrEmpty), 32'(mLevel == 0));
        checkOutput("busy", 32'(busyOut), 32'(mMode != 0));
        checkOutput("wdog_err", 32'(wdogErr), 32'(mErr));
    endtask

    task automatic applyStimulus(input int inW, input int outS, input bit wrD, input bit rdD);
        @(negedge clk);
        inFifoWords  = LVL_WIDTH'(inW);
        outFifoSpace = LVL_WIDTH'(outS);
        wrDone       = wrD;
        rdDone       = rdD;
        @(posedge clk);
        modelStep(inW, outS, wrD, rdD);
        #1;
        checkAll();
    endtask

    // Done pulses answer the model's in-flight burst after a random wait, plus occasional strays.
    task automatic runPhase(input int cycles, input int inW, input int outS, input bit randomLevels);
        int wIn, sOut;
        bit wd, rd;
        for (int i = 0; i < cycles; i++) begin
            wIn = inW;
            sOut = outS;
            if (randomLevels) begin
                wIn = $urandom_range(0, 40);
                sOut = $urandom_range(0, 40);
            end
            wd = (mMode == 1) && ($urandom_range(0, 2) == 0);
            rd = (mMode == 2) && ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) == 0) wd = 1;
            if ($urandom_range(0, 19) == 0) rd = 1;
            applyStimulus(wIn, sOut, wd, rd);
        end
    endtask

    task automatic runUntilLevel(input string tag, input int inW, input int outS, input int target);
        int guard;
        guard = 0;
        while (!(mLevel == target && mMode == 0) && guard < 300) begin
            runPhase(1, inW, outS, 0);
            guard++;
        end
        checkOutput(tag, 32'(ddrLevel), 32'(target));
    endtask

    initial begin
        modelReset();
        #12;
        checkAll();
        @(negedge clk);
        rst_n = 1'b1;

        runUntilLevel("fill_to_full", 16, 0, REGION_BURSTS);
        runPhase(20, 16, 0, 0);
        runUntilLevel("drain_to_empty", 0, 16, 0);
        runPhase(20, 0, 16, 0);

        runUntilLevel("prefill_two", 16, 0, 2);
        runPhase(120, 16, 16, 0);

        runUntilLevel("settle_one", 0, 16, 1);
        runPhase(8, 15, 0, 0);
        runPhase(12, 16, 0, 0);

        runPhase(500, 0, 0, 1);

        runUntilLevel("drain_before_reset", 0, 16, 0);
        applyStimulus(16, 0, 0, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        inFifoWords = '0;
        outFifoSpace = '0;
        wrDone = 1'b0;
        rdDone = 1'b0;
        modelReset();
        #1;
        checkAll();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 1, 0);
        checkOutput("level_after_stray_done", 32'(ddrLevel), 32'd0);

        runPhase(60, 16, 16, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
